// File: rtl/alt_seq_pkg.sv
// alt_seq_pkg: shared types and helpers for the alternating-pattern stimulus transmitter.
package alt_seq_pkg;
  typedef enum logic [1:0] {ALT, RUN, DOUBLE, RSVD} alt_mode_e;
  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_e;
  localparam int DEFAULT_MAX_LEN = 16;
  // Bit k of a burst depends only on the low two counter bits; RSVD behaves as RUN.
  function automatic logic bit_at(alt_mode_e m, logic first, logic [1:0] k);
    return m == ALT ? first ^ k[0] : m == DOUBLE ? first ^ k[1] : first;
  endfunction
endpackage

// File: rtl/alt_seq_tx_if.sv
// alt_seq_tx_if: command handshake plus serial bit stream of the transmitter.
interface alt_seq_tx_if #(
  parameter int MAX_LEN = alt_seq_pkg::DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_first_i;
  logic [1:0]       cmd_mode_i;
  logic             x_o;
  logic             x_valid_o;
  logic             tx_ready_i;
  logic             expect_o;
  logic             done_o;
  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_first_i, cmd_mode_i, tx_ready_i,
    output cmd_ready_o, x_o, x_valid_o, expect_o, done_o
  );
  modport master (
    output cmd_valid_i, cmd_len_i, cmd_first_i, cmd_mode_i, tx_ready_i,
    input  cmd_ready_o, x_o, x_valid_o, expect_o, done_o
  );
endinterface

// File: rtl/alt_seq_history.sv
// alt_seq_history: last two accepted bits and the predicted detector output for the current bit.
module alt_seq_history (
  input  logic clk,
  input  logic reset,
  input  logic x,
  input  logic x_valid,
  input  logic accept,
  output logic expect_o
);
  logic h1_q, h2_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else if (accept) begin
      h2_q <= h1_q;
      h1_q <= x;
    end
  assign expect_o = x_valid && (x != h1_q) && (h1_q != h2_q);
endmodule

// File: rtl/alt_seq_tx.sv
// alt_seq_tx: serialises burst commands into alternating/run/double-toggle bit patterns
// with the detector output each bit should produce.
module alt_seq_tx
  import alt_seq_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic         clk,
  input logic         reset,
  alt_seq_tx_if.slave bus
);
  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] k_q, k_d, len_q, len_d, len_c;
  alt_mode_e        mode_q, mode_d;
  logic             first_q, first_d, x_q, x_d, accept, last;
  assign len_c  = bus.cmd_len_i > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cmd_len_i;
  assign accept = state_q == SEND && bus.tx_ready_i;
  assign last   = k_q + 1'b1 == len_q;
  // k holds on the last bit so it never reaches len.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    mode_d  = mode_q;
    first_d = first_q;
    x_d     = x_q;
    if (state_q == IDLE && bus.cmd_valid_i) begin
      len_d   = len_c;
      mode_d  = alt_mode_e'(bus.cmd_mode_i);
      first_d = bus.cmd_first_i;
      k_d     = '0;
      x_d     = bus.cmd_first_i;
      state_d = len_c == '0 ? DONE : SEND;
    end else if (accept) begin
      k_d     = last ? k_q : k_q + 1'b1;
      x_d     = last ? x_q : bit_at(mode_q, first_q, k_d[1:0]);
      state_d = last ? DONE : SEND;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
      mode_q  <= ALT;
      first_q <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      x_q     <= x_d;
    end
  assign bus.cmd_ready_o = state_q == IDLE;
  assign bus.x_valid_o   = state_q == SEND;
  assign bus.x_o         = x_q;
  assign bus.done_o      = state_q == DONE;
  alt_seq_history u_hist (
    .clk      (clk),
    .reset    (reset),
    .x        (x_q),
    .x_valid  (bus.x_valid_o),
    .accept   (accept),
    .expect_o (bus.expect_o)
  );
endmodule

// File: tb/tb_alt_seq_tx.sv
// tb_alt_seq_tx: directed and randomized bursts checked against a queue-based model.
module tb_alt_seq_tx;
  localparam int MAX_LEN = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int nb = 0;
  bit q[$];
  bit h1 = 0;
  bit h2 = 0;
  bit done_now = 0;
  alt_seq_tx_if #(.MAX_LEN(MAX_LEN)) bus ();
  alt_seq_tx #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input int len, input bit f, input int m, input bit r);
    bit busy, e;
    int n;
    @(negedge clk);
    busy = q.size() > 0;
    e = busy && ({h2, h1, q[0]} == 3'b101 || {h2, h1, q[0]} == 3'b010);
    chk("x_valid", bus.x_valid_o, busy);
    if (busy) chk("x", bus.x_o, q[0]);
    chk("expect", bus.expect_o, e);
    chk("done", bus.done_o, done_now);
    chk("ready", bus.cmd_ready_o, !busy && !done_now);
    bus.cmd_valid_i = v;
    bus.cmd_len_i   = 5'(len);
    bus.cmd_first_i = f;
    bus.cmd_mode_i  = 2'(m);
    bus.tx_ready_i  = r;
    @(posedge clk);
    if (done_now) done_now = 0;
    else if (busy) begin
      if (r) begin
        nb++;
        h2 = h1;
        h1 = q.pop_front();
        if (q.size() == 0) done_now = 1;
      end
    end else if (v) begin
      n = len > MAX_LEN ? MAX_LEN : len;
      for (int i = 0; i < n; i++)
        q.push_back(m == 0 ? f ^ bit'(i % 2) : m == 2 ? f ^ bit'((i / 2) % 2) : f);
      if (n == 0) done_now = 1;
    end
  endtask

  task automatic do_reset();
    bus.cmd_valid_i = 0;
    #3 reset = 1;
    #1;
    chk("rst_x_valid", bus.x_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_ready", bus.cmd_ready_o, 1);
    chk("rst_expect", bus.expect_o, 0);
    q.delete();
    h1 = 0;
    h2 = 0;
    done_now = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bus.cmd_valid_i = 0;
    bus.cmd_len_i   = '0;
    bus.cmd_first_i = 0;
    bus.cmd_mode_i  = '0;
    bus.tx_ready_i  = 0;
    repeat (2) @(negedge clk);
    chk("reset_x", bus.x_o, 0);
    chk("reset_x_valid", bus.x_valid_o, 0);
    chk("reset_done", bus.done_o, 0);
    chk("reset_ready", bus.cmd_ready_o, 1);
    chk("reset_expect", bus.expect_o, 0);
    reset = 0;
    step(1, 4, 1, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    step(1, 3, 1, 1, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(1, 6, 0, 2, 1);
    repeat (8) step(0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    nb = 0;
    step(1, 20, 1, 0, 1);
    repeat (16) step(1, 5, 0, 1, 1);
    chk("len20_bits", nb, 16);
    repeat (8) step(0, 0, 0, 0, 1);
    step(1, 8, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    do_reset();
    step(1, 4, 1, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 20), 1'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
